// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet transmitter:
//   tx_state_t       - transmitter FSM states
//   ADDR_INVALID     - destination code that is never routable
//   BUF_DEPTH_DEF    - default payload buffer depth in bytes
//   GAP_CYCLES_DEF   - default idle cycles after each parity byte
// ---------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    localparam logic [1:0] ADDR_INVALID   = 2'b11;
    localparam int         BUF_DEPTH_DEF  = 64;
    localparam int         GAP_CYCLES_DEF = 2;

endpackage : router_pkg

// File: rtl/router_tx_buf.sv
// ---------------------------------------------------------------------------
// router_tx_buf
// Payload byte FIFO with first-word-fall-through read data.
//   clk, rst  - clock, asynchronous active-high reset
//   wr_en     - push wr_data (dropped while full)
//   wr_data   - byte to push
//   pop       - advance past the current head byte (ignored while empty)
//   rd_data   - current head byte
//   count     - occupancy, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
// ---------------------------------------------------------------------------
module router_tx_buf #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          pop_ok;

    // Fullness is judged on the registered count, so a push into a full
    // buffer is dropped even when a pop happens on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
            if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count
    // already makes old contents unreachable, and it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule : router_tx_buf

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Builds router packets: header {pld_len, dest_addr}, pld_len payload bytes
// from the internal buffer, then an XOR parity byte, then an idle gap.
//   clk, rst     - clock, asynchronous active-high reset
//   buf_wr_en    - write buf_wr_data into the payload buffer (any state)
//   buf_wr_data  - payload byte
//   start        - send request, honoured only while ready=1
//   dest_addr    - destination port (2'b11 rejected)
//   pld_len      - payload length, 1..63 (0 rejected)
//   busy         - router stall; holds the current output byte
//   data_out     - registered byte stream
//   pkt_vld      - registered, high for header and payload bytes
//   ready        - FSM is idle
//   buf_full     - buffer holds BUF_DEPTH bytes
//   buf_count    - buffer occupancy
//   done         - pulse the cycle after the parity byte is accepted
//   err          - pulse the cycle after a start is rejected
// ---------------------------------------------------------------------------
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         buf_wr_en,
    input  logic [7:0]                   buf_wr_data,
    input  logic                         start,
    input  logic [1:0]                   dest_addr,
    input  logic [5:0]                   pld_len,
    input  logic                         busy,
    output logic [7:0]                   data_out,
    output logic                         pkt_vld,
    output logic                         ready,
    output logic                         buf_full,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         done,
    output logic                         err
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t  state_q, state_d;
    logic [7:0] data_d;
    logic       vld_d;
    logic       done_d;
    logic       err_d;
    logic [5:0] len_q, len_d;       // latched payload length
    logic [5:0] sent_q, sent_d;     // payload bytes loaded into data_out
    logic [7:0] acc_q, acc_d;       // XOR of every byte loaded so far
    logic [GAP_W-1:0] gap_q, gap_d;

    logic       buf_pop;
    logic [7:0] buf_rd_data;
    logic       buf_empty;

    router_tx_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_data (buf_wr_data),
        .pop     (buf_pop),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign ready = (state_q == ST_IDLE);

    // Next-state logic computes the value each output register takes on the
    // coming edge; busy only gates whether that value changes, so there is no
    // combinational path from busy to data_out/pkt_vld.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d = state_q;
        data_d  = data_out;
        vld_d   = pkt_vld;
        done_d  = 1'b0;
        err_d   = 1'b0;
        len_d   = len_q;
        sent_d  = sent_q;
        acc_d   = acc_q;
        gap_d   = gap_q;
        buf_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dest_addr != ADDR_INVALID && pld_len != 6'd0 &&
                        buf_count >= CNT_W'(pld_len)) begin
                        state_d = ST_HEADER;
                        len_d   = pld_len;
                        sent_d  = 6'd0;
                        data_d  = {pld_len, dest_addr};
                        vld_d   = 1'b1;
                        acc_d   = {pld_len, dest_addr};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    state_d = ST_PAYLOAD;
                    data_d  = buf_rd_data;
                    acc_d   = acc_q ^ buf_rd_data;
                    buf_pop = !buf_empty;
                    sent_d  = 6'd1;
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    if (sent_q == len_q) begin
                        state_d = ST_PARITY;
                        data_d  = acc_q;
                        vld_d   = 1'b0;
                    end else begin
                        data_d  = buf_rd_data;
                        acc_d   = acc_q ^ buf_rd_data;
                        buf_pop = !buf_empty;
                        sent_d  = sent_q + 6'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    done_d  = 1'b1;
                    data_d  = 8'h00;
                    vld_d   = 1'b0;
                    acc_d   = 8'h00;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                                 gap_d   = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_out <= 8'h00;
            pkt_vld  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            len_q    <= 6'd0;
            sent_q   <= 6'd0;
            acc_q    <= 8'h00;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_out <= data_d;
            pkt_vld  <= vld_d;
            done     <= done_d;
            err      <= err_d;
            len_q    <= len_d;
            sent_q   <= sent_d;
            acc_q    <= acc_d;
            gap_q    <= gap_d;
        end
    end

endmodule : router_pkt_tx

// File: tb/tb_router_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_tx
// Self-checking bench for router_pkt_tx. The buffer is modelled as a byte
// queue and each packet as a list of expected bytes built from its header,
// buffer order and XOR parity. Inputs change and outputs are sampled just
// after the falling edge.
// ---------------------------------------------------------------------------
module tb_router_pkt_tx;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       buf_wr_en;
    logic [7:0] buf_wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pld_len;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_vld;
    logic       ready;
    logic       buf_full;
    logic [6:0] buf_count;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mq[$];   // model of buffer contents, head first

    router_pkt_tx dut (
        .clk         (clk),
        .rst         (rst),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_data (buf_wr_data),
        .start       (start),
        .dest_addr   (dest_addr),
        .pld_len     (pld_len),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_vld     (pkt_vld),
        .ready       (ready),
        .buf_full    (buf_full),
        .buf_count   (buf_count),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [7:0] b);
        buf_wr_en   = 1'b1;
        buf_wr_data = b;
        @(negedge clk);
        buf_wr_en   = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(b);
    endtask

    task automatic reject(input logic [1:0] a, input logic [5:0] l);
        start     = 1'b1;
        dest_addr = a;
        pld_len   = l;
        @(negedge clk);
        start = 1'b0;
        check("rej_err", err, 1);
        check("rej_ready", ready, 1);
        check("rej_vld", pkt_vld, 0);
        @(negedge clk);
        check("rej_err_pulse", err, 0);
        check("rej_count", buf_count, mq.size());
    endtask

    // Sends one packet. busy is asserted randomly with busy_pct percent, and
    // additionally forced for hold_n cycles while stream item hold_idx is shown.
    // With wr_pct>0, random bytes are written into the buffer during the packet.
    task automatic send(input logic [1:0] a, input logic [5:0] l, input int busy_pct,
                        input int hold_idx, input int hold_n, input int wr_pct);
        logic [7:0] exp[$];
        logic [7:0] par;
        int idx;
        int hold_left;
        int shown;
        int last;
        exp.push_back({l, a});
        for (int i = 0; i < int'(l); i++) exp.push_back(mq.pop_front());
        par = 8'h00;
        foreach (exp[i]) par = par ^ exp[i];
        exp.push_back(par);
        last = int'(l) + 1;

        check("pre_ready", ready, 1);
        start     = 1'b1;
        dest_addr = a;
        pld_len   = l;
        @(negedge clk);
        start = 1'b0;

        idx       = 0;
        hold_left = hold_n;
        shown     = 0;
        while (idx <= last) begin
            check($sformatf("data[%0d]", idx), data_out, exp[idx]);
            check($sformatf("vld[%0d]", idx), pkt_vld, (idx < last) ? 1 : 0);
            check("busy_ready", ready, 0);
            check("busy_done", done, 0);
            check("busy_err", err, 0);
            shown++;
            if (idx == hold_idx && hold_left > 0) begin
                busy = 1'b1;
                hold_left--;
            end else begin
                busy = ($urandom_range(99) < busy_pct);
            end
            // A start mid-packet must be ignored without err.
            start     = ($urandom_range(3) == 0);
            dest_addr = 2'($urandom_range(3));
            pld_len   = 6'($urandom_range(63));
            buf_wr_en = 1'b0;
            if (wr_pct > 0 && $urandom_range(99) < wr_pct &&
                mq.size() + int'(l) < DEPTH - 4) begin
                buf_wr_en   = 1'b1;
                buf_wr_data = 8'($urandom);
            end
            @(negedge clk);
            if (buf_wr_en) mq.push_back(buf_wr_data);
            buf_wr_en = 1'b0;
            if (!busy) begin
                if (idx == hold_idx && hold_n > 0)
                    check("hold_cycles", shown, hold_n + 1);
                idx++;
                shown = 0;
            end
        end
        busy  = 1'b0;
        start = 1'b0;
        check("done_pulse", done, 1);
        check("gap1_vld", pkt_vld, 0);
        check("gap1_data", data_out, 0);
        check("gap1_ready", ready, 0);
        @(negedge clk);
        check("gap2_done", done, 0);
        check("gap2_data", data_out, 0);
        check("gap2_ready", ready, 0);
        @(negedge clk);
        check("post_ready", ready, 1);
        check("post_vld", pkt_vld, 0);
        check("post_count", buf_count, mq.size());
    endtask

    initial begin
        rst         = 1'b1;
        buf_wr_en   = 1'b0;
        buf_wr_data = 8'h00;
        start       = 1'b0;
        dest_addr   = 2'd0;
        pld_len     = 6'd0;
        busy        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", data_out, 0);
        check("rst_vld", pkt_vld, 0);
        check("rst_count", buf_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_full", buf_full, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Basic packet, then the same packet with a 3-cycle stall on 0x22.
        wr(8'h11); wr(8'h22); wr(8'h33);
        check("basic_count", buf_count, 3);
        send(2'd1, 6'd3, 0, -1, 0, 0);
        wr(8'h11); wr(8'h22); wr(8'h33);
        send(2'd1, 6'd3, 0, 2, 3, 0);

        // Rejected starts.
        wr(8'h5A); wr(8'hC3);
        reject(2'd3, 6'd1);
        reject(2'd1, 6'd0);
        reject(2'd0, 6'd5);
        send(2'd2, 6'd2, 0, -1, 0, 0);

        // Full buffer, dropped write, 63-byte packet, refill across the wrap.
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
        check("full_flag", buf_full, 1);
        check("full_count", buf_count, 64);
        wr(8'hAA);
        check("drop_count", buf_count, 64);
        check("drop_full", buf_full, 1);
        send(2'd0, 6'd63, 20, -1, 0, 0);
        check("remain_count", buf_count, 1);
        check("remain_full", buf_full, 0);
        for (int i = 0; i < 40; i++) wr(8'($urandom));
        send(2'd1, 6'd41, 20, -1, 0, 0);

        // Reset in the middle of a payload.
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        start     = 1'b1;
        dest_addr = 2'd2;
        pld_len   = 6'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_vld", pkt_vld, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_vld", pkt_vld, 0);
        check("arst_count", buf_count, 0);
        check("arst_ready", ready, 1);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_done", done, 0);
        for (int i = 0; i < 3; i++) wr(8'($urandom));
        send(2'd0, 6'd3, 0, -1, 0, 0);

        // Randomised packets with stalls and concurrent writes.
        for (int p = 0; p < 20; p++) begin
            int n;
            int len;
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) wr(8'($urandom));
            len = $urandom_range(1, (mq.size() > 63) ? 63 : mq.size());
            send(2'($urandom_range(2)), 6'(len), 30, -1, 0, 25);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_router_pkt_tx

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, payload buffer depth in bytes (power of two, >= 63).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced after each parity byte.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 buf_wr_en  in  1  write one payload byte into the internal buffer.
REQ-006 buf_wr_data  in  8  payload byte to write.
REQ-007 start  in  1  request to send one packet; sampled only while ready=1.
REQ-008 dest_addr  in  2  destination port; 2'b11 is invalid.
REQ-009 pld_len  in  6  payload byte count; 1..63 legal, 0 is invalid.
REQ-010 busy  in  1  router stall; while high, the current output byte is held.
REQ-011 data_out  out  8  byte stream to the router din.
REQ-012 pkt_vld  out  1  high for header and payload bytes, low for the parity byte and when idle.
REQ-013 ready  out  1  high only in IDLE.
REQ-014 buf_full  out  1  buffer occupancy equals BUF_DEPTH.
REQ-015 buf_count  out  7  buffer occupancy.
REQ-016 done  out  1  one-cycle pulse on the cycle the parity byte is accepted.
REQ-017 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-018 SHALL implement FSM IDLE -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE.
REQ-019 IDLE: start=1 with dest_addr!=3, pld_len!=0, buf_count>=pld_len SHALL latch addr/len and move to HEADER; any other start SHALL pulse err next cycle and remain IDLE.
REQ-020 The header byte SHALL be {pld_len, dest_addr} and SHALL appear on data_out with pkt_vld=1 on the cycle after start is accepted.
REQ-021 Each byte SHALL be accepted (and the FSM/counter advance) on a rising edge with busy=0; with busy=1, data_out and pkt_vld SHALL hold unchanged.
REQ-022 PAYLOAD SHALL pop exactly pld_len bytes in buffer order, pkt_vld=1, with one byte per accepted cycle.
REQ-023 PARITY SHALL drive pkt_vld=0 and data_out equal to the XOR of the header and all payload bytes, held until accepted.
REQ-024 done SHALL pulse on the cycle after the parity byte is accepted; GAP SHALL then last GAP_CYCLES cycles with pkt_vld=0 and data_out=0.
REQ-025 Outputs data_out and pkt_vld SHALL be registered; no combinational path from busy to them.
REQ-026 Buffer writes SHALL be allowed in any state; a write while buf_full=1 SHALL be dropped (fullness evaluated before a same-cycle pop).
REQ-027 Simultaneous write and pop at neither full nor empty SHALL leave buf_count unchanged.
REQ-028 Buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-029 start while not in IDLE SHALL be ignored, with no err.

Reset
REQ-030 rst SHALL asynchronously force the state to IDLE, data_out=0, pkt_vld=0, done=0, err=0, parity accumulator=0, buffer pointers and buf_count=0, and ready=1 after release.
REQ-031 Reset mid-packet SHALL abort the packet with no parity byte emitted and discard buffered payload.

Structure
REQ-032 Shared package router_pkg SHALL hold the FSM state enum, ADDR_INVALID=2'b11, and defaults for BUF_DEPTH and GAP_CYCLES.
REQ-033 The payload buffer SHALL be a sub-module router_tx_buf (sync write/pop, count, full, empty).

Verification
REQ-034 Write 0x11,0x22,0x33; start addr=1, len=3, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_vld=1, then 0x0D with pkt_vld=0, done pulse, two gap cycles, ready=1.
REQ-035 Same packet with busy=1 for 3 cycles during 0x22 -> 0x22 is held 4 cycles, with no byte lost or duplicated.
REQ-036 start with addr=3, len=0, or buf_count=2 with len=5 -> err pulse, ready stays 1, pkt_vld stays 0.
REQ-037 Fill 64 bytes, then write 0xAA -> buf_full=1, count=64, 0xAA dropped; send len=63 -> 1 byte remains, and the pointer wraps correctly on the refill.
REQ-038 Assert rst during PAYLOAD -> pkt_vld=0 immediately, buf_count=0, and the next packet's parity is correct.
